dev_bridge: RTL
===============

Name: dev_bridge

Overview:
- Sits between the CPU data-memory port and up to four memory-mapped peripherals (data memory, timers, I/O).
- Takes one CPU load/store request and decodes its address to exactly one device, then drives that device's select and the shared write bus.
- Waits for the device acknowledge, then returns the read data (or an error) to the CPU as a one-cycle response.
- It is the distribution side of the datapath: one source fanned out to many targets, with read data steered back.

Parameters:
- DEV_BASE0, 32'h0000_0000, base address of device 0
- DEV_MASK0, 32'hFFFF_C000, compare mask of device 0 (address bits where the mask is 1 must equal the base)
- DEV_BASE1, 32'h0000_7F00, base of device 1
- DEV_MASK1, 32'hFFFF_FFF0, mask of device 1
- DEV_BASE2, 32'h0000_7F10, base of device 2
- DEV_MASK2, 32'hFFFF_FFF0, mask of device 2
- DEV_BASE3, 32'h0000_7F20, base of device 3
- DEV_MASK3, 32'hFFFF_FFF0, mask of device 3
- TIMEOUT, 16, maximum number of cycles in WAIT before the access is aborted (must be ≥ 2)

Ports:
- clk  in  1  system clock; one clock domain, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_be  in  4  byte enables
- cpu_wdata  in  32  store data
- cpu_busy  out  1  high whenever state != IDLE
- cpu_rvalid  out  1  one-cycle response strobe
- cpu_rdata  out  32  load data, valid while cpu_rvalid is high
- cpu_err  out  1  unmapped address or timeout, valid while cpu_rvalid is high
- dev_sel  out  4  one-hot device select
- dev_we  out  1  shared write enable, gated by dev_sel
- dev_addr  out  32  offset within the device window: cpu_addr & ~DEV_MASKk
- dev_be  out  4  shared byte enables
- dev_wdata  out  32  shared write data
- dev_ack  in  4  per-device acknowledge
- dev_rdata  in  128  per-device read data; device k occupies bits [32k+31:32k]

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE and every output is 0. A reset during WAIT or DONE aborts the transaction; no cpu_rvalid is produced, and dev_sel is 0 from the first cycle after the reset edge.
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE, cpu_req=0: stay in IDLE.
- IDLE, cpu_req=1: decode the address. Device k hits when (cpu_addr & DEV_MASKk) == (DEV_BASEk & DEV_MASKk). If several devices hit, the lowest index wins.
- IDLE, cpu_req=1 with a hit on device k: latch we/be/wdata and the offset. Set dev_sel = 1<<k, clear the counter, go to WAIT.
- IDLE, cpu_req=1 with no hit: go to DONE with cpu_err=1 and cpu_rdata=0. dev_sel stays 0.
- WAIT: dev_sel, dev_we, dev_addr, dev_be and dev_wdata are held stable. The counter increments every cycle.
- WAIT, dev_ack[k]=1 for the selected k: on a load, capture the k-th dev_rdata slice into cpu_rdata; on a store, set cpu_rdata=0. Set err=0, clear dev_sel and dev_we, go to DONE.
- Acknowledges on unselected devices are ignored.
- WAIT, counter == TIMEOUT-1 with no valid ack: go to DONE with err=1, rdata=0, dev_sel cleared. If a valid ack arrives on that same cycle, the ack wins.
- DONE: cpu_rvalid=1 for exactly one cycle; cpu_busy=1; cpu_req is ignored. Next state is always IDLE, where cpu_rvalid, cpu_rdata and cpu_err return to 0.
- Latency (req is cycle 0):
  - ack in the first WAIT cycle (cycle 1) gives cpu_rvalid in cycle 2;
  - unmapped address gives cpu_rvalid in cycle 1;
  - timeout gives cpu_rvalid in cycle TIMEOUT+1.
- Throughput: at most one transaction in flight. A new request is accepted no earlier than the cycle after DONE.
- cpu_be=0 is forwarded unchanged; it is not treated as an error.

Decomposition:
- Package bridge_pkg holds: state encoding (IDLE/WAIT/DONE), NDEV=4, data width 32, and the default TIMEOUT.
- Sub-module bridge_addr_decode is combinational: inputs cpu_addr plus the base/mask parameters; outputs a one-hot hit vector after the priority pick, and a no-hit flag. The FSM and datapath registers stay in dev_bridge.

Test Plan:
- Store to 32'h0000_7F04, wdata 32'hDEAD_BEEF, be 4'hF; ack from device 1 in cycle 1 -> dev_sel=4'b0010 and dev_addr=32'h4 in cycle 1; cpu_rvalid=1, cpu_err=0, cpu_rdata=0 in cycle 2.
- Load from 32'h0000_0010; device 0 acks after 3 WAIT cycles with dev_rdata[31:0]=32'h1234_5678 -> cpu_rdata=32'h1234_5678, cpu_err=0; cpu_busy=1 throughout; dev_sel returns to 0 after the ack.
- Load from unmapped 32'h0000_9000 -> dev_sel never asserted; cpu_rvalid=1 with cpu_err=1 and cpu_rdata=0 in cycle 1.
- Load from 32'h0000_7F14 with no ack -> cpu_err=1 in cycle TIMEOUT+1; a stray dev_ack[3] pulse mid-wait is ignored.
- Ack on the same cycle as counter == TIMEOUT-1 -> cpu_err=0 and data is captured. cpu_req pulsed during DONE -> ignored, no second transaction.
- Assert reset in the second WAIT cycle -> next cycle dev_sel=0 and all outputs 0; no cpu_rvalid; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge.
package bridge_pkg;
  localparam int NDEV        = 4;
  localparam int DW          = 32;
  localparam int AW          = 32;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decode: base/mask match per device, lowest index wins.
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter logic [AW-1:0] DEV_BASE0 = 32'h0000_0000,
  parameter logic [AW-1:0] DEV_MASK0 = 32'hFFFF_C000,
  parameter logic [AW-1:0] DEV_BASE1 = 32'h0000_7F00,
  parameter logic [AW-1:0] DEV_MASK1 = 32'hFFFF_FFF0,
  parameter logic [AW-1:0] DEV_BASE2 = 32'h0000_7F10,
  parameter logic [AW-1:0] DEV_MASK2 = 32'hFFFF_FFF0,
  parameter logic [AW-1:0] DEV_BASE3 = 32'h0000_7F20,
  parameter logic [AW-1:0] DEV_MASK3 = 32'hFFFF_FFF0
) (
  input  logic [AW-1:0]   cpu_addr_i,
  output logic [NDEV-1:0] hit_o,
  output logic            no_hit_o
);

  localparam logic [NDEV-1:0][AW-1:0] BASES = {DEV_BASE3, DEV_BASE2, DEV_BASE1, DEV_BASE0};
  localparam logic [NDEV-1:0][AW-1:0] MASKS = {DEV_MASK3, DEV_MASK2, DEV_MASK1, DEV_MASK0};

  logic [NDEV-1:0] raw_hit;

  always_comb begin
    raw_hit = '0;
    for (int k = 0; k < NDEV; k++) begin
      raw_hit[k] = ((cpu_addr_i & MASKS[k]) == (BASES[k] & MASKS[k]));
    end
  end

  // Walk from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit_o = '0;
    for (int k = NDEV - 1; k >= 0; k--) begin
      if (raw_hit[k]) begin
        hit_o    = '0;
        hit_o[k] = 1'b1;
      end
    end
  end

  assign no_hit_o = ~|raw_hit;

endmodule

// File: rtl/dev_bridge.sv
// CPU data-port bridge: decodes one request to a single device, waits for its
// acknowledge (or a timeout) and returns a one-cycle registered response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction; cpu_req sampled and decoded
//   WAIT    | device selected, bus held stable, counting toward timeout
//   DONE    | one-cycle response on cpu_rvalid, cpu_req ignored
module dev_bridge
  import bridge_pkg::*;
#(
  parameter logic [AW-1:0] DEV_BASE0 = 32'h0000_0000,
  parameter logic [AW-1:0] DEV_MASK0 = 32'hFFFF_C000,
  parameter logic [AW-1:0] DEV_BASE1 = 32'h0000_7F00,
  parameter logic [AW-1:0] DEV_MASK1 = 32'hFFFF_FFF0,
  parameter logic [AW-1:0] DEV_BASE2 = 32'h0000_7F10,
  parameter logic [AW-1:0] DEV_MASK2 = 32'hFFFF_FFF0,
  parameter logic [AW-1:0] DEV_BASE3 = 32'h0000_7F20,
  parameter logic [AW-1:0] DEV_MASK3 = 32'hFFFF_FFF0,
  parameter int            TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [3:0]           cpu_be,
  input  logic [DW-1:0]        cpu_wdata,
  output logic                 cpu_busy,
  output logic                 cpu_rvalid,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_err,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_we,
  output logic [AW-1:0]        dev_addr,
  output logic [3:0]           dev_be,
  output logic [DW-1:0]        dev_wdata,
  input  logic [NDEV-1:0]      dev_ack,
  input  logic [NDEV*DW-1:0]   dev_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NDEV-1:0][AW-1:0] MASKS = {DEV_MASK3, DEV_MASK2, DEV_MASK1, DEV_MASK0};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [NDEV-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic [NDEV-1:0]   hit;
  logic              no_hit;
  logic [AW-1:0]     win_mask;
  logic              ack_hit;
  logic [DW-1:0]     sel_rdata;

  bridge_addr_decode #(
    .DEV_BASE0(DEV_BASE0), .DEV_MASK0(DEV_MASK0),
    .DEV_BASE1(DEV_BASE1), .DEV_MASK1(DEV_MASK1),
    .DEV_BASE2(DEV_BASE2), .DEV_MASK2(DEV_MASK2),
    .DEV_BASE3(DEV_BASE3), .DEV_MASK3(DEV_MASK3)
  ) u_decode (
    .cpu_addr_i(cpu_addr),
    .hit_o     (hit),
    .no_hit_o  (no_hit)
  );

  always_comb begin
    win_mask = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (hit[k]) win_mask = MASKS[k];
    end
  end

  // Only the selected device's ack and read slice are looked at.
  always_comb begin
    ack_hit   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (sel_q[k]) begin
        ack_hit   = dev_ack[k];
        sel_rdata = dev_rdata[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (cpu_req) begin
          if (no_hit) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            sel_d   = hit;
            we_d    = cpu_we;
            addr_d  = cpu_addr & ~win_mask;
            be_d    = cpu_be;
            wdata_d = cpu_wdata;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (ack_hit) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        rdata_d = '0;
        err_d   = 1'b0;
        sel_d   = '0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    rvalid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cpu_busy   = busy_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;
  assign dev_sel    = sel_q;
  assign dev_we     = we_q;
  assign dev_addr   = addr_q;
  assign dev_be     = be_q;
  assign dev_wdata  = wdata_q;

endmodule
